proc_dmem_arb: RTL and testbench

PROC_DMEM_ARB -- requirements
Module: proc_dmem_arb

---
 rtl/proc_dmem_arb_pkg.sv | 12 +
 rtl/proc_dmem_arb_wait_ctr.sv | 29 ++
 rtl/proc_dmem_arb.sv | 117 +++++++++++
 tb/tb_proc_dmem_arb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/proc_dmem_arb_pkg.sv
// Shared types for the processor / external data-memory arbiter.
package proc_dmem_arb_pkg;

    typedef enum logic {
        PRI_PROC = 1'b0,
        PRI_EXT  = 1'b1
    } arb_state_e;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/proc_dmem_arb_wait_ctr.sv
// Saturating count of consecutive cycles the ext requester has been denied.
module proc_dmem_arb_wait_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] count_next
);

    logic [3:0] count;

    always_comb begin
        count_next = count;
        if (clr)
            count_next = '0;
        else if (inc && count != 4'(MAX_WAIT))
            count_next = count + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/proc_dmem_arb.sv
// Arbitrates the processor and an external requester onto one data-memory port,
// with a one-cycle registered response and starvation protection for ext.
module proc_dmem_arb
    import proc_dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        proc_req_val,
    output logic        proc_req_rdy,
    input  logic        proc_req_type,
    input  logic [31:0] proc_req_addr,
    input  logic [31:0] proc_req_wdata,
    output logic        proc_resp_val,
    output logic [31:0] proc_resp_rdata,

    input  logic        ext_req_val,
    output logic        ext_req_rdy,
    input  logic        ext_req_type,
    input  logic [31:0] ext_req_addr,
    input  logic [31:0] ext_req_wdata,
    output logic        ext_resp_val,
    output logic [31:0] ext_resp_rdata,

    output logic        mem_req_val,
    output logic        mem_req_type,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic [31:0] mem_resp_rdata
);

    arb_state_e state, state_next;
    logic       proc_grant, ext_grant;
    logic [3:0] wait_cnt_next;

    // Grants are held off while reset is asserted so no access leaks out.
    always_comb begin
        proc_grant = 1'b0;
        ext_grant  = 1'b0;
        if (rst) begin
            if (proc_req_val && ext_req_val) begin
                if (state == PRI_EXT)
                    ext_grant = 1'b1;
                else
                    proc_grant = 1'b1;
            end else begin
                proc_grant = proc_req_val;
                ext_grant  = ext_req_val;
            end
        end
    end

    assign proc_req_rdy = proc_grant;
    assign ext_req_rdy  = ext_grant;

    proc_dmem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .inc        (ext_req_val && !ext_grant),
        .clr        (ext_grant || !ext_req_val),
        .count_next (wait_cnt_next)
    );

    // Switching on the count's next value lets ext win on the very next cycle.
    always_comb begin
        state_next = state;
        case (state)
            PRI_PROC: if (wait_cnt_next == 4'(MAX_WAIT)) state_next = PRI_EXT;
            PRI_EXT:  if (ext_grant)                     state_next = PRI_PROC;
            default:  state_next = PRI_PROC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= PRI_PROC;
        else
            state <= state_next;
    end

    always_comb begin
        mem_req_val   = 1'b0;
        mem_req_type  = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        if (proc_grant) begin
            mem_req_val   = 1'b1;
            mem_req_type  = proc_req_type;
            mem_req_addr  = proc_req_addr;
            mem_req_wdata = proc_req_wdata;
        end else if (ext_grant) begin
            mem_req_val   = 1'b1;
            mem_req_type  = ext_req_type;
            mem_req_addr  = ext_req_addr;
            mem_req_wdata = ext_req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proc_resp_val   <= 1'b0;
            proc_resp_rdata <= '0;
            ext_resp_val    <= 1'b0;
            ext_resp_rdata  <= '0;
        end else begin
            proc_resp_val   <= proc_grant;
            proc_resp_rdata <= (proc_grant && proc_req_type == REQ_READ) ? mem_resp_rdata : '0;
            ext_resp_val    <= ext_grant;
            ext_resp_rdata  <= (ext_grant && ext_req_type == REQ_READ) ? mem_resp_rdata : '0;
        end
    end

endmodule

// File: tb/tb_proc_dmem_arb.sv
// Directed bench for proc_dmem_arb: a small harness memory plus a response
// scoreboard filled from the bench's own reference memory.
module tb_proc_dmem_arb;
    import proc_dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        proc_req_val, proc_req_rdy, proc_req_type;
    logic [31:0] proc_req_addr, proc_req_wdata;
    logic        proc_resp_val;
    logic [31:0] proc_resp_rdata;
    logic        ext_req_val, ext_req_rdy, ext_req_type;
    logic [31:0] ext_req_addr, ext_req_wdata;
    logic        ext_resp_val;
    logic [31:0] ext_resp_rdata;
    logic        mem_req_val, mem_req_type;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;

    always #5 clk = ~clk;

    proc_dmem_arb #(.MAX_WAIT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .proc_req_val    (proc_req_val),
        .proc_req_rdy    (proc_req_rdy),
        .proc_req_type   (proc_req_type),
        .proc_req_addr   (proc_req_addr),
        .proc_req_wdata  (proc_req_wdata),
        .proc_resp_val   (proc_resp_val),
        .proc_resp_rdata (proc_resp_rdata),
        .ext_req_val     (ext_req_val),
        .ext_req_rdy     (ext_req_rdy),
        .ext_req_type    (ext_req_type),
        .ext_req_addr    (ext_req_addr),
        .ext_req_wdata   (ext_req_wdata),
        .ext_resp_val    (ext_resp_val),
        .ext_resp_rdata  (ext_resp_rdata),
        .mem_req_val     (mem_req_val),
        .mem_req_type    (mem_req_type),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_resp_rdata  (mem_resp_rdata)
    );

    // Harness memory driven by the DUT; rmem is the bench's independent reference.
    logic [31:0] hmem [256];
    logic [31:0] rmem [256];

    assign mem_resp_rdata = hmem[mem_req_addr[9:2]];

    always @(posedge clk)
        if (mem_req_val && mem_req_type == REQ_WRITE)
            hmem[mem_req_addr[9:2]] <= mem_req_wdata;

    typedef struct {
        logic        to_proc;
        logic [31:0] rdata;
    } resp_t;

    resp_t sb[$];
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic step(input string tag,
                        input logic pv, input logic pt, input logic [31:0] pa, input logic [31:0] pd,
                        input logic ev, input logic et, input logic [31:0] ea, input logic [31:0] ed,
                        input logic epg, input logic eeg);
        resp_t       r;
        logic        xt;
        logic [31:0] xa, xd;
        proc_req_val = pv; proc_req_type = pt; proc_req_addr = pa; proc_req_wdata = pd;
        ext_req_val  = ev; ext_req_type  = et; ext_req_addr  = ea; ext_req_wdata  = ed;
        #1;
        xt = epg ? pt : (eeg ? et : 1'b0);
        xa = epg ? pa : (eeg ? ea : 32'h0);
        xd = epg ? pd : (eeg ? ed : 32'h0);
        chk({tag, ".proc_rdy"}, 32'(proc_req_rdy), 32'(epg));
        chk({tag, ".ext_rdy"},  32'(ext_req_rdy),  32'(eeg));
        chk({tag, ".mem_val"},  32'(mem_req_val),  32'(epg | eeg));
        chk({tag, ".mem_type"}, 32'(mem_req_type), 32'(xt));
        chk({tag, ".mem_addr"}, mem_req_addr, xa);
        chk({tag, ".mem_wdata"}, mem_req_wdata, xd);
        if (epg || eeg) begin
            r.to_proc = epg;
            r.rdata   = (xt == REQ_READ) ? rmem[xa[9:2]] : 32'h0;
            if (xt == REQ_WRITE) rmem[xa[9:2]] = xd;
            sb.push_back(r);
        end
        @(posedge clk);
        @(negedge clk);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk({tag, ".proc_resp_val"},   32'(proc_resp_val), 32'(r.to_proc));
            chk({tag, ".proc_resp_rdata"}, proc_resp_rdata, r.to_proc ? r.rdata : 32'h0);
            chk({tag, ".ext_resp_val"},    32'(ext_resp_val),  32'(!r.to_proc));
            chk({tag, ".ext_resp_rdata"},  ext_resp_rdata,  r.to_proc ? 32'h0 : r.rdata);
        end else begin
            chk({tag, ".proc_resp_val"},   32'(proc_resp_val), 32'h0);
            chk({tag, ".proc_resp_rdata"}, proc_resp_rdata, 32'h0);
            chk({tag, ".ext_resp_val"},    32'(ext_resp_val),  32'h0);
            chk({tag, ".ext_resp_rdata"},  ext_resp_rdata,  32'h0);
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".proc_rdy"},        32'(proc_req_rdy),  32'h0);
        chk({tag, ".ext_rdy"},         32'(ext_req_rdy),   32'h0);
        chk({tag, ".mem_val"},         32'(mem_req_val),   32'h0);
        chk({tag, ".mem_addr"},        mem_req_addr,       32'h0);
        chk({tag, ".proc_resp_val"},   32'(proc_resp_val), 32'h0);
        chk({tag, ".proc_resp_rdata"}, proc_resp_rdata,    32'h0);
        chk({tag, ".ext_resp_val"},    32'(ext_resp_val),  32'h0);
        chk({tag, ".ext_resp_rdata"},  ext_resp_rdata,     32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            hmem[i] = 32'hC0DE_0000 | 32'(i);
            rmem[i] = 32'hC0DE_0000 | 32'(i);
        end

        // Reset with requests pending: nothing may be granted.
        rst = 1'b0;
        proc_req_val = 1'b1; proc_req_type = REQ_READ; proc_req_addr = 32'h100; proc_req_wdata = 32'h0;
        ext_req_val  = 1'b1; ext_req_type  = REQ_READ; ext_req_addr  = 32'h200; ext_req_wdata  = 32'h0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Proc-only write then read back; first grant right after reset release.
        step("pw", 1'b1, REQ_WRITE, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("pr", 1'b1, REQ_READ,  32'h100, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("pr.literal", rmem[8'h40], 32'hDEADBEEF);

        idle("idle", 10);

        // Continuous tie: proc x4, ext, proc.
        for (int i = 0; i < 6; i++)
            step($sformatf("tie%0d", i), 1'b1, REQ_READ, 32'h10 + 32'(i * 4), 32'h0,
                 1'b1, REQ_READ, 32'h300, 32'h0, i != 4, i == 4);
        idle("tie_gap", 1);

        // Ext write then proc read of the same word on the next cycle.
        step("xw", 1'b0, REQ_READ, 32'h0, 32'h0, 1'b1, REQ_WRITE, 32'h200, 32'h12345678, 1'b0, 1'b1);
        step("xr", 1'b1, REQ_READ, 32'h200, 32'h0, 1'b0, REQ_READ, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("xr.literal", rmem[8'h80], 32'h12345678);

        // Ext denied twice, drops val, then needs four fresh denials before winning.
        for (int i = 0; i < 8; i++)
            step($sformatf("starve%0d", i), 1'b1, REQ_WRITE, 32'h40 + 32'(i * 4), 32'hA000_0000 | 32'(i),
                 (i != 2), REQ_READ, 32'h80, 32'h0, i != 7, i == 7);
        step("starve_after", 1'b1, REQ_READ, 32'h44, 32'h0, 1'b1, REQ_READ, 32'h84, 32'h0, 1'b1, 1'b0);
        idle("starve_gap", 1);

        // Proc write then ext read of the same address.
        step("pw2", 1'b1, REQ_WRITE, 32'h3C0, 32'h0BADF00D, 1'b0, REQ_READ, 32'h0, 32'h0, 1'b1, 1'b0);
        step("xr2", 1'b0, REQ_READ, 32'h0, 32'h0, 1'b1, REQ_READ, 32'h3C0, 32'h0, 1'b0, 1'b1);

        // Reset arriving while a read response is on the outputs.
        proc_req_val = 1'b1; proc_req_type = REQ_READ; proc_req_addr = 32'h100; proc_req_wdata = 32'h0;
        ext_req_val  = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.resp_before", 32'(proc_resp_val), 32'h1);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid");
        proc_req_val = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle("post_reset", 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
